// File: rtl/area_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : area_arbiter
// Brief   : Round-robin share of one /dav-rfd area (X*Y) unit between two
//           /dav-rfd clients, one job in flight at a time.
// Revision: 1.0  initial release
// ============================================================================
module area_arbiter #(
   parameter int W      = 8,
   parameter bit PRIO_B = 1'b0
) (
   input  logic             clock,
   input  logic             reset_,
   // client A
   input  logic [W-1:0]     a_x,
   input  logic [W-1:0]     a_y,
   input  logic             a_dav_,
   output logic             a_rfd,
   output logic [2*W-1:0]   a_area,
   output logic             a_adav_,
   input  logic             a_arfd,
   // client B
   input  logic [W-1:0]     b_x,
   input  logic [W-1:0]     b_y,
   input  logic             b_dav_,
   output logic             b_rfd,
   output logic [2*W-1:0]   b_area,
   output logic             b_adav_,
   input  logic             b_arfd,
   // area unit
   output logic [W-1:0]     u_x,
   output logic [W-1:0]     u_y,
   output logic             u_dav_,
   input  logic             u_rfd,
   input  logic [2*W-1:0]   u_area,
   input  logic             u_adav_,
   output logic             u_arfd,
   // status
   output logic             busy,
   output logic             gnt,
   output logic [7:0]       jobs
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ACK_IN  = 3'd1,
      S_SEND    = 3'd2,
      S_SEND_W  = 3'd3,
      S_RECV    = 3'd4,
      S_RECV_W  = 3'd5,
      S_DELIV   = 3'd6,
      S_DELIV_W = 3'd7
   } state_t;

   state_t           r_state, w_state;
   logic [W-1:0]     r_x, w_x;
   logic [W-1:0]     r_y, w_y;
   logic [2*W-1:0]   r_r, w_r;
   logic             r_a_rfd, w_a_rfd;
   logic             r_b_rfd, w_b_rfd;
   logic             r_a_adav_, w_a_adav_;
   logic             r_b_adav_, w_b_adav_;
   logic             r_u_dav_, w_u_dav_;
   logic             r_u_arfd, w_u_arfd;
   logic             r_gnt, w_gnt;
   logic             r_last, w_last;
   logic [7:0]       r_jobs, w_jobs;

   logic             w_pick_b;
   logic             w_sel_dav_;
   logic             w_sel_arfd;

   // Contention goes to whoever was not served last; a lone requester always wins.
   assign w_pick_b   = (!a_dav_ && !b_dav_) ? ~r_last : ~b_dav_;
   assign w_sel_dav_ = r_gnt ? b_dav_ : a_dav_;
   assign w_sel_arfd = r_gnt ? b_arfd : a_arfd;

   always_comb begin
      w_state   = r_state;
      w_x       = r_x;
      w_y       = r_y;
      w_r       = r_r;
      w_a_rfd   = r_a_rfd;
      w_b_rfd   = r_b_rfd;
      w_a_adav_ = r_a_adav_;
      w_b_adav_ = r_b_adav_;
      w_u_dav_  = r_u_dav_;
      w_u_arfd  = r_u_arfd;
      w_gnt     = r_gnt;
      w_last    = r_last;
      w_jobs    = r_jobs;
      case (r_state)
         S_IDLE: begin
            if (!a_dav_ || !b_dav_) begin
               w_gnt = w_pick_b;
               w_x   = w_pick_b ? b_x : a_x;
               w_y   = w_pick_b ? b_y : a_y;
               if (w_pick_b) w_b_rfd = 1'b0;
               else          w_a_rfd = 1'b0;
               w_state = S_ACK_IN;
            end
         end
         S_ACK_IN: begin
            if (w_sel_dav_) begin
               if (r_gnt) w_b_rfd = 1'b1;
               else       w_a_rfd = 1'b1;
               w_state = S_SEND;
            end
         end
         S_SEND: begin
            if (u_rfd) begin
               w_u_dav_ = 1'b0;
               w_state  = S_SEND_W;
            end
         end
         S_SEND_W: begin
            if (!u_rfd) begin
               w_u_dav_ = 1'b1;
               w_state  = S_RECV;
            end
         end
         S_RECV: begin
            if (!u_adav_) begin
               w_r      = u_area;
               w_u_arfd = 1'b0;
               w_state  = S_RECV_W;
            end
         end
         S_RECV_W: begin
            if (u_adav_) begin
               w_u_arfd = 1'b1;
               w_state  = S_DELIV;
            end
         end
         S_DELIV: begin
            if (w_sel_arfd) begin
               if (r_gnt) w_b_adav_ = 1'b0;
               else       w_a_adav_ = 1'b0;
               w_state = S_DELIV_W;
            end
         end
         S_DELIV_W: begin
            if (!w_sel_arfd) begin
               if (r_gnt) w_b_adav_ = 1'b1;
               else       w_a_adav_ = 1'b1;
               w_last  = r_gnt;
               w_jobs  = r_jobs + 8'd1;
               w_state = S_IDLE;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_) begin
         r_state   <= S_IDLE;
         r_x       <= '0;
         r_y       <= '0;
         r_r       <= '0;
         r_a_rfd   <= 1'b1;
         r_b_rfd   <= 1'b1;
         r_a_adav_ <= 1'b1;
         r_b_adav_ <= 1'b1;
         r_u_dav_  <= 1'b1;
         r_u_arfd  <= 1'b1;
         r_gnt     <= PRIO_B;
         r_last    <= ~PRIO_B;
         r_jobs    <= 8'd0;
      end else begin
         r_state   <= w_state;
         r_x       <= w_x;
         r_y       <= w_y;
         r_r       <= w_r;
         r_a_rfd   <= w_a_rfd;
         r_b_rfd   <= w_b_rfd;
         r_a_adav_ <= w_a_adav_;
         r_b_adav_ <= w_b_adav_;
         r_u_dav_  <= w_u_dav_;
         r_u_arfd  <= w_u_arfd;
         r_gnt     <= w_gnt;
         r_last    <= w_last;
         r_jobs    <= w_jobs;
      end
   end

   // Both clients see the same result register; only the granted one gets adav_.
   assign a_rfd   = r_a_rfd;
   assign a_area  = r_r;
   assign a_adav_ = r_a_adav_;
   assign b_rfd   = r_b_rfd;
   assign b_area  = r_r;
   assign b_adav_ = r_b_adav_;
   assign u_x     = r_x;
   assign u_y     = r_y;
   assign u_dav_  = r_u_dav_;
   assign u_arfd  = r_u_arfd;
   assign busy    = (r_state != S_IDLE);
   assign gnt     = r_gnt;
   assign jobs    = r_jobs;

endmodule
`default_nettype wire
